// File: rtl/io_out_port_hub.sv
// Output-port endpoint: four registered ports loaded by CPU write strobes, plus a
// show-ahead event FIFO (one entry per write event) drained over valid/ready.
module io_out_port_hub #(
  parameter int DW    = 8,
  parameter int DEPTH = 4
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   rwe1,
  input  logic                   rwe2,
  input  logic                   rwe3,
  input  logic                   rwe4,
  input  logic [DW-1:0]          wdata,
  input  logic                   clr_ovf,
  output logic [DW-1:0]          port0,
  output logic [DW-1:0]          port1,
  output logic [DW-1:0]          port2,
  output logic [DW-1:0]          port3,
  output logic                   out_valid,
  output logic [1:0]             out_id,
  output logic                   out_bcast,
  output logic [DW-1:0]          out_data,
  input  logic                   out_ready,
  output logic                   full,
  output logic [$clog2(DEPTH):0] count,
  output logic                   overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int EW = DW + 3;

  logic [3:0]    w_strobes;
  logic          w_any;
  logic          w_multi;
  logic [1:0]    w_id;
  logic [EW-1:0] w_entry;
  logic          w_pop;
  logic          w_push;
  logic          w_drop;
  logic [CW-1:0] w_count_nxt;

  logic [EW-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          r_valid;
  logic          r_full;
  logic          r_overflow;
  logic [EW-1:0] r_head;
  logic [DW-1:0] r_port0;
  logic [DW-1:0] r_port1;
  logic [DW-1:0] r_port2;
  logic [DW-1:0] r_port3;

  assign w_strobes = {rwe4, rwe3, rwe2, rwe1};
  assign w_any     = |w_strobes;
  assign w_multi   = (w_strobes & (w_strobes - 4'd1)) != 4'd0;

  // Multi-strobe writes (e.g. PRINT) report the lowest asserted port index.
  always_comb begin
    w_id = 2'd3;
    if (rwe1)      w_id = 2'd0;
    else if (rwe2) w_id = 2'd1;
    else if (rwe3) w_id = 2'd2;
  end

  assign w_entry     = {w_multi, w_id, wdata};
  assign w_pop       = r_valid && out_ready;
  assign w_push      = w_any && (!r_full || w_pop);
  assign w_drop      = w_any && r_full && !w_pop;
  assign w_count_nxt = r_count + CW'(w_push) - CW'(w_pop);

  always_ff @(posedge clock) begin
    if (reset) begin
      r_port0 <= '0;
      r_port1 <= '0;
      r_port2 <= '0;
      r_port3 <= '0;
    end else begin
      if (rwe1) r_port0 <= wdata;
      if (rwe2) r_port1 <= wdata;
      if (rwe3) r_port2 <= wdata;
      if (rwe4) r_port3 <= wdata;
    end
  end

  always_ff @(posedge clock) begin
    if (w_push && !reset) r_mem[r_wr_ptr] <= w_entry;
  end

  // Head is a separate register so its fields hold their last value once empty.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_valid    <= 1'b0;
      r_full     <= 1'b0;
      r_overflow <= 1'b0;
      r_head     <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      r_count <= w_count_nxt;
      r_valid <= w_count_nxt != '0;
      r_full  <= w_count_nxt == CW'(DEPTH);
      if (w_drop)       r_overflow <= 1'b1;
      else if (clr_ovf) r_overflow <= 1'b0;
      if (w_pop && r_count > CW'(1))
        r_head <= r_mem[r_rd_ptr + AW'(1)];
      else if (w_push && (r_count == '0 || (w_pop && r_count == CW'(1))))
        r_head <= w_entry;
    end
  end

  assign port0     = r_port0;
  assign port1     = r_port1;
  assign port2     = r_port2;
  assign port3     = r_port3;
  assign out_valid = r_valid;
  assign out_bcast = r_head[EW-1];
  assign out_id    = r_head[DW+1:DW];
  assign out_data  = r_head[DW-1:0];
  assign full      = r_full;
  assign count     = r_count;
  assign overflow  = r_overflow;

endmodule

// File: tb/tb_io_out_port_hub.sv
// Directed bench for io_out_port_hub: a queue scoreboard models the event FIFO,
// an array models the ports, and immediate assertions compare after every edge.
module tb_io_out_port_hub;

  localparam int DW    = 8;
  localparam int DEPTH = 4;

  typedef struct packed {
    logic       bcast;
    logic [1:0] id;
    logic [7:0] data;
  } entry_t;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          rwe1 = 1'b0, rwe2 = 1'b0, rwe3 = 1'b0, rwe4 = 1'b0;
  logic [DW-1:0] wdata = '0;
  logic          clr_ovf = 1'b0;
  logic          out_ready = 1'b0;
  logic [DW-1:0] port0, port1, port2, port3;
  logic          out_valid, out_bcast, full, overflow;
  logic [1:0]    out_id;
  logic [DW-1:0] out_data;
  logic [2:0]    count;

  entry_t     sbQueue[$];
  logic [7:0] expPort [4];
  logic       expOvf;
  int         testCount = 0;
  int         failCount = 0;

  io_out_port_hub #(.DW(DW), .DEPTH(DEPTH)) dut (
    .clock(clock), .reset(reset),
    .rwe1(rwe1), .rwe2(rwe2), .rwe3(rwe3), .rwe4(rwe4),
    .wdata(wdata), .clr_ovf(clr_ovf),
    .port0(port0), .port1(port1), .port2(port2), .port3(port3),
    .out_valid(out_valid), .out_id(out_id), .out_bcast(out_bcast),
    .out_data(out_data), .out_ready(out_ready),
    .full(full), .count(count), .overflow(overflow)
  );

  always #5 clock = ~clock;

  task automatic checkVal(input string name, input logic [31:0] observed, input logic [31:0] expected);
    testCount++;
    assert (observed === expected)
      else begin
        failCount++;
        $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", name, observed, expected);
      end
  endtask

  // Compares every DUT output against the scoreboard and port model.
  task automatic checkOutput(input string tag);
    checkVal({tag, ".port0"}, 32'(port0), 32'(expPort[0]));
    checkVal({tag, ".port1"}, 32'(port1), 32'(expPort[1]));
    checkVal({tag, ".port2"}, 32'(port2), 32'(expPort[2]));
    checkVal({tag, ".port3"}, 32'(port3), 32'(expPort[3]));
    checkVal({tag, ".valid"}, 32'(out_valid), 32'(sbQueue.size() != 0));
    checkVal({tag, ".count"}, 32'(count), 32'(sbQueue.size()));
    checkVal({tag, ".full"}, 32'(full), 32'(sbQueue.size() == DEPTH));
    checkVal({tag, ".overflow"}, 32'(overflow), 32'(expOvf));
    if (sbQueue.size() != 0) begin
      checkVal({tag, ".id"}, 32'(out_id), 32'(sbQueue[0].id));
      checkVal({tag, ".bcast"}, 32'(out_bcast), 32'(sbQueue[0].bcast));
      checkVal({tag, ".data"}, 32'(out_data), 32'(sbQueue[0].data));
    end
  endtask

  // Drives one cycle of inputs, advances the model at the edge, then checks.
  task automatic applyStimulus(input string tag, input logic [3:0] rwe, input logic [7:0] data,
                               input logic ready, input logic clr, input logic rst);
    entry_t e;
    logic   popNow;
    {rwe4, rwe3, rwe2, rwe1} = rwe;
    wdata     = data;
    out_ready = ready;
    clr_ovf   = clr;
    reset     = rst;
    @(posedge clock);
    if (rst) begin
      sbQueue.delete();
      for (int i = 0; i < 4; i++) expPort[i] = 8'h00;
      expOvf = 1'b0;
    end else begin
      for (int i = 0; i < 4; i++) if (rwe[i]) expPort[i] = data;
      popNow = (sbQueue.size() != 0) && ready;
      if (popNow) void'(sbQueue.pop_front());
      if (rwe != 4'b0000) begin
        if (sbQueue.size() < DEPTH) begin
          e.bcast = ($countones(rwe) > 1);
          e.id    = rwe[0] ? 2'd0 : rwe[1] ? 2'd1 : rwe[2] ? 2'd2 : 2'd3;
          e.data  = data;
          sbQueue.push_back(e);
        end else begin
          expOvf = 1'b1;
        end
      end else if (clr) begin
        expOvf = 1'b0;
      end
      if (rwe != 4'b0000 && clr && sbQueue.size() < DEPTH && !expOvf) expOvf = 1'b0;
    end
    #1;
    {rwe4, rwe3, rwe2, rwe1} = 4'b0000;
    reset = 1'b0;
    clr_ovf = 1'b0;
    checkOutput(tag);
  endtask

  initial begin
    for (int i = 0; i < 4; i++) expPort[i] = 8'h00;
    expOvf = 1'b0;

    applyStimulus("rst0", 4'b0000, 8'h00, 1'b0, 1'b0, 1'b1);
    applyStimulus("rst1", 4'b0000, 8'h00, 1'b0, 1'b0, 1'b1);
    checkVal("rst.out_id", 32'(out_id), 32'd0);
    checkVal("rst.out_data", 32'(out_data), 32'd0);
    checkVal("rst.out_bcast", 32'(out_bcast), 32'd0);

    // Single strobe on rwe2
    applyStimulus("t1", 4'b0010, 8'h5A, 1'b0, 1'b0, 1'b0);
    checkVal("t1.port1", 32'(port1), 32'h5A);
    checkVal("t1.port0", 32'(port0), 32'h00);
    checkVal("t1.out_id", 32'(out_id), 32'd1);
    checkVal("t1.out_data", 32'(out_data), 32'h5A);
    checkVal("t1.count", 32'(count), 32'd1);
    applyStimulus("t1.drain", 4'b0000, 8'h00, 1'b1, 1'b0, 1'b0);

    // PRINT: all strobes, one broadcast entry
    applyStimulus("t2", 4'b1111, 8'hC3, 1'b0, 1'b0, 1'b0);
    checkVal("t2.port3", 32'(port3), 32'hC3);
    checkVal("t2.out_id", 32'(out_id), 32'd0);
    checkVal("t2.out_bcast", 32'(out_bcast), 32'd1);
    checkVal("t2.count", 32'(count), 32'd1);
    applyStimulus("t2.drain", 4'b0000, 8'h00, 1'b1, 1'b0, 1'b0);

    // Overfill with consumer stalled, then drain in order
    for (int i = 1; i <= 5; i++) applyStimulus("t3.fill", 4'b0001, 8'(i), 1'b0, 1'b0, 1'b0);
    checkVal("t3.count", 32'(count), 32'd4);
    checkVal("t3.full", 32'(full), 32'd1);
    checkVal("t3.overflow", 32'(overflow), 32'd1);
    checkVal("t3.port0", 32'(port0), 32'h05);
    checkVal("t3.head", 32'(out_data), 32'h01);
    for (int i = 0; i < 4; i++) applyStimulus("t3.drain", 4'b0000, 8'h00, 1'b1, 1'b0, 1'b0);
    checkVal("t3.valid_after", 32'(out_valid), 32'd0);
    applyStimulus("t3.clr", 4'b0000, 8'h00, 1'b0, 1'b1, 1'b0);
    checkVal("t3.ovf_clr", 32'(overflow), 32'd0);

    // Push while full with simultaneous pop, then wrap the pointers
    for (int i = 0; i < 4; i++) applyStimulus("t4.fill", 4'b0010, 8'h20 + 8'(i), 1'b0, 1'b0, 1'b0);
    applyStimulus("t4.pushpop", 4'b0010, 8'h77, 1'b1, 1'b0, 1'b0);
    checkVal("t4.count", 32'(count), 32'd4);
    checkVal("t4.overflow", 32'(overflow), 32'd0);
    checkVal("t4.head", 32'(out_data), 32'h21);
    for (int i = 0; i < 8; i++) applyStimulus("t4.wrap", 4'b0100, 8'h80 + 8'(i), 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) applyStimulus("t4.drain", 4'b0000, 8'h00, 1'b1, 1'b0, 1'b0);
    checkVal("t4.empty", 32'(out_valid), 32'd0);

    // Ready while empty plus a write: entry must be kept
    applyStimulus("t5.empty_push", 4'b1000, 8'h10, 1'b1, 1'b0, 1'b0);
    checkVal("t5.out_id", 32'(out_id), 32'd3);
    checkVal("t5.count", 32'(count), 32'd1);
    for (int i = 0; i < 3; i++) applyStimulus("t5.fill", 4'b0001, 8'h40 + 8'(i), 1'b0, 1'b0, 1'b0);
    applyStimulus("t5.drop_clr", 4'b0001, 8'h4F, 1'b0, 1'b1, 1'b0);
    checkVal("t5.drop_wins", 32'(overflow), 32'd1);
    applyStimulus("t5.clr", 4'b0000, 8'h00, 1'b0, 1'b1, 1'b0);
    checkVal("t5.cleared", 32'(overflow), 32'd0);

    // Reset with three queued entries and a concurrent rwe3
    applyStimulus("t6.pop", 4'b0000, 8'h00, 1'b1, 1'b0, 1'b0);
    checkVal("t6.count3", 32'(count), 32'd3);
    applyStimulus("t6.reset", 4'b0100, 8'hEE, 1'b0, 1'b0, 1'b1);
    checkVal("t6.port2", 32'(port2), 32'h00);
    checkVal("t6.count", 32'(count), 32'd0);
    checkVal("t6.out_data", 32'(out_data), 32'd0);
    checkVal("t6.out_id", 32'(out_id), 32'd0);

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
